// File: rtl/io_uart_tx_if.sv
// CPU-side I/O port pair of the UART transmitter: io_out carries requests
// from the CPU, io_in returns ack and status to the CPU.
interface io_uart_tx_if;
  logic [31:0] io_out;
  logic [31:0] io_in;

  modport master (output io_out, input io_in);
  modport slave  (input io_out, output io_in);
endinterface

// File: rtl/io_uart_tx.sv
// Toggle-request byte writer feeding a small FIFO and an 8N1 UART serializer.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit (8E1).
module io_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rstn,
  io_uart_tx_if.slave cpu,
  output logic        tx,
  output logic        tx_active
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  // FIFO and request-decode state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          last_req_q;
  logic          ovf_q, ovf_d;
  logic          full_q, empty_q;

  // Transmitter state
  state_e        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic          tx_q;
  logic          busy_q;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic       req_c, push_c, pop_c, drop_c;
  logic [7:0] head_c;
  logic       unused_c;

  assign unused_c = ^cpu.io_out[31:10];
  assign head_c   = mem_q[rd_ptr_q];

  // A pop happens when the serializer is ready for a byte: idle, or the last stop-bit cycle
  assign pop_c  = !empty_q &&
                  ((state_q == S_IDLE) || ((state_q == S_STOP) && (baud_q == '0)));
  assign req_c  = cpu.io_out[8] != last_req_q;
  assign push_c = req_c && (!full_q || pop_c);
  assign drop_c = req_c && full_q && !pop_c;

  // Next occupancy and sticky overflow (a set beats a same-cycle clear)
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop_c) begin
      ovf_d = 1'b1;
    end else if (cpu.io_out[9]) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO storage; contents need no reset since the pointers/count define validity
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= cpu.io_out[7:0];
    end
  end

  // FIFO pointers, occupancy, status flags and request tracking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      last_req_q <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q    <= count_d;
      full_q     <= (count_d == DEPTH_C);
      empty_q    <= (count_d == '0);
      ovf_q      <= ovf_d;
      // Whether accepted or dropped, every request is acknowledged
      last_req_q <= cpu.io_out[8];
    end
  end

  // Serializer FSM with registered line and busy outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      if (pop_c) begin
        shreg_q <= head_c;
`ifdef UART_TX_PARITY_EN
        par_q   <= ^head_c;
`endif
      end
      case (state_q)
        S_IDLE: begin
          if (pop_c) begin
            state_q <= S_START;
            baud_q  <= BAUD_LAST;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (baud_q == '0) begin
            state_q   <= S_DATA;
            baud_q    <= BAUD_LAST;
            bit_idx_q <= '0;
            tx_q      <= shreg_q[0];
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        S_DATA: begin
          if (baud_q == '0) begin
            baud_q <= BAUD_LAST;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              shreg_q   <= {1'b0, shreg_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shreg_q[1];
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_q == '0) begin
            state_q <= S_STOP;
            baud_q  <= BAUD_LAST;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_q == '0) begin
            if (pop_c) begin
              // Next byte waiting: start bit follows the stop bit with no gap
              state_q <= S_START;
              baud_q  <= BAUD_LAST;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            baud_q <= baud_q - BW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx        = tx_q;
  assign tx_active = busy_q;
  assign cpu.io_in = {8'h00, 8'(count_q), 3'b000, busy_q, empty_q, full_q,
                      ovf_q, last_req_q, 8'h00};

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: table of single-byte frames plus
// hand-written sequences for back-to-back, overflow, push/pop collision and reset.
module tb_io_uart_tx;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_CYC = 11 * CPB;
`else
  localparam int FRAME_CYC = 10 * CPB;
`endif
  localparam int NV = 7;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit 0 = first bit on the wire (start), bit 9 = stop
    logic       par;
  } vec_t;

  logic clk;
  logic rstn;
  logic tx;
  logic tx_active;
  io_uart_tx_if bus ();

  io_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cpu      (bus),
    .tx       (tx),
    .tx_active(tx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vec_cnt;
  int   err_cnt;
  logic tog;
  int   peak_occ;
  bit   track_peak;
  int   w;
  int   elapsed;
  int   bad;
  vec_t vecs [NV];

  always @(negedge clk) begin
    if (track_peak && int'(bus.io_in[23:16]) > peak_occ) peak_occ = int'(bus.io_in[23:16]);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [9:0] line_of(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // Toggle the request bit and poll (bounded) for the matching ack
  task automatic send_req(input logic [7:0] d, input logic clr, output int waited);
    tog = ~tog;
    bus.io_out = {22'd0, clr, tog, d};
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.io_in[8] !== tog && waited < 8);
    check("ack", 32'(bus.io_in[8]), 32'(tog));
  endtask

  // Sample one frame mid-bit starting at frame cycle 'skip'; leaves the bench at
  // frame cycle FRAME_CYC, i.e. cycle 0 of any directly following frame.
  task automatic check_frame(input string name, input logic [9:0] line, input logic par,
                             input int skip, input int inject_at, input logic [7:0] inj);
    logic [10:0] expb;
    logic [10:0] gotb;
    int busy;
`ifdef UART_TX_PARITY_EN
    expb = {line[9], par, line[8:0]};
`else
    expb = {1'b0, line};
    if (par) expb = expb;
`endif
    gotb = '0;
    busy = skip;
    for (int c = skip; c < FRAME_CYC; c++) begin
      if (c % CPB == CPB / 2) gotb[c / CPB] = tx;
      if (tx_active) busy++;
      if (c == inject_at) begin
        tog = ~tog;
        bus.io_out = {22'd0, 1'b0, tog, inj};
      end
      @(negedge clk);
    end
    check({name, " bits"}, 32'(gotb), 32'(expb));
    check({name, " busy cycles"}, 32'(busy), 32'(FRAME_CYC));
  endtask

  task automatic check_idle(input string name);
    check(name, {29'd0, tx_active, bus.io_in[11], tx}, 32'b011);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    tog = 1'b0;
    peak_occ = 0;
    track_peak = 0;
    vecs[0] = '{8'hA5, 10'h34A, 1'b0};
    vecs[1] = '{8'h3C, 10'h278, 1'b0};
    vecs[2] = '{8'hFF, 10'h3FE, 1'b0};
    vecs[3] = '{8'h07, 10'h20E, 1'b1};
    vecs[4] = '{8'h03, 10'h206, 1'b0};
    vecs[5] = '{8'h80, 10'h300, 1'b1};
    vecs[6] = '{8'h00, 10'h200, 1'b0};

    // Reset state
    bus.io_out = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset tx_active", 32'(tx_active), 32'd0);
    check("reset io_in", bus.io_in, 32'h0000_0800);
    rstn = 1'b1;
    @(negedge clk);

    // First request: exact status words around push and pop
    tog = 1'b1;
    bus.io_out = 32'h0000_0155;
    @(negedge clk);
    check("push io_in", bus.io_in, 32'h0001_0100);
    @(negedge clk);
    check("pop io_in", bus.io_in, 32'h0000_1900);
    check("start tx", 32'(tx), 32'd0);
    check_frame("frame 0x55", 10'h2AA, 1'b0, 0, -1, 8'h00);
    check_idle("idle after 0x55");

    // Table: one isolated frame per vector
    for (int i = 0; i < NV; i++) begin
      send_req(vecs[i].data, 1'b0, w);
      check($sformatf("vec%0d occ after push", i), 32'(bus.io_in[23:16]), 32'd1);
      @(negedge clk);
      check($sformatf("vec%0d tx start", i), 32'(tx), 32'd0);
      check($sformatf("vec%0d occ after pop", i), 32'(bus.io_in[23:16]), 32'd0);
      check_frame($sformatf("vec%0d", i), vecs[i].line, vecs[i].par, 0, -1, 8'h00);
      check_idle($sformatf("vec%0d idle", i));
    end

    // Back-to-back frames with ack polling
    peak_occ = 0;
    track_peak = 1;
    send_req(8'hA5, 1'b0, w);
    send_req(8'h3C, 1'b0, w);
    send_req(8'hFF, 1'b0, w);
    check_frame("b2b 0xA5", 10'h34A, 1'b0, w, -1, 8'h00);
    check_frame("b2b 0x3C", 10'h278, 1'b0, 0, -1, 8'h00);
    check_frame("b2b 0xFF", 10'h3FE, 1'b0, 0, -1, 8'h00);
    track_peak = 0;
    check("b2b peak occupancy", 32'(peak_occ), 32'd2);
    check_idle("b2b idle");

    // Overflow: six requests into a depth-4 FIFO while busy; sixth also clears (set wins)
    send_req(8'h11, 1'b0, w);
    send_req(8'h12, 1'b0, w);
    elapsed = 0;
    for (int k = 3; k <= 5; k++) begin
      send_req(8'h10 + 8'(k), 1'b0, w);
      elapsed += w;
    end
    check("ovf clear before full", 32'(bus.io_in[9]), 32'd0);
    send_req(8'h16, 1'b1, w);
    elapsed += w;
    check("ovf set wins", 32'(bus.io_in[9]), 32'd1);
    check("ovf full", 32'(bus.io_in[10]), 32'd1);
    check("ovf occ", 32'(bus.io_in[23:16]), 32'd4);
    bus.io_out[9] = 1'b0;
    @(negedge clk);
    elapsed++;
    check("ovf sticky", 32'(bus.io_in[9]), 32'd1);
    bus.io_out[9] = 1'b1;
    @(negedge clk);
    elapsed++;
    bus.io_out[9] = 1'b0;
    check("ovf cleared", 32'(bus.io_in[9]), 32'd0);
    check_frame("ovf 0x11", line_of(8'h11), ^8'h11, elapsed, -1, 8'h00);
    for (int k = 2; k <= 5; k++) begin
      check_frame($sformatf("ovf 0x1%0d", k), line_of(8'h10 + 8'(k)), ^(8'h10 + 8'(k)),
                  0, -1, 8'h00);
    end
    check_idle("ovf idle, no sixth byte");

    // Request on a full FIFO exactly at the stop-to-start pop edge
    send_req(8'h21, 1'b0, w);
    send_req(8'h22, 1'b0, w);
    elapsed = 0;
    for (int k = 3; k <= 5; k++) begin
      send_req(8'h20 + 8'(k), 1'b0, w);
      elapsed += w;
    end
    check("pp full", 32'(bus.io_in[10]), 32'd1);
    check_frame("pp 0x21", line_of(8'h21), ^8'h21, elapsed, FRAME_CYC - 1, 8'h26);
    check("pp ack", 32'(bus.io_in[8]), 32'(tog));
    check("pp occ", 32'(bus.io_in[23:16]), 32'd4);
    check("pp no ovf", 32'(bus.io_in[9]), 32'd0);
    for (int k = 2; k <= 6; k++) begin
      check_frame($sformatf("pp 0x2%0d", k), line_of(8'h20 + 8'(k)), ^(8'h20 + 8'(k)),
                  0, -1, 8'h00);
    end
    check_idle("pp idle");

    // Reset during data bit 3 with a second byte queued
    send_req(8'h31, 1'b0, w);
    send_req(8'h32, 1'b0, w);
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    check("mid tx low before reset", 32'(tx), 32'd0);
    rstn = 1'b0;
    #1;
    check("mid reset tx", 32'(tx), 32'd1);
    check("mid reset tx_active", 32'(tx_active), 32'd0);
    check("mid reset io_in", bus.io_in, 32'h0000_0800);
    tog = 1'b0;
    bus.io_out = '0;
    @(negedge clk);
    rstn = 1'b1;
    bad = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_active !== 1'b0) bad++;
    end
    check("no residual bytes", 32'(bad), 32'd0);
    check("post reset io_in", bus.io_in, 32'h0000_0800);

    // Request bit already set at reset release is enqueued on the first edge
    rstn = 1'b0;
    tog = 1'b1;
    bus.io_out = 32'h0000_01C3;
    @(negedge clk);
    check("held reset io_in", bus.io_in, 32'h0000_0800);
    rstn = 1'b1;
    @(negedge clk);
    check("release push io_in", bus.io_in, 32'h0001_0100);
    @(negedge clk);
    check("release tx start", 32'(tx), 32'd0);
    check_frame("release 0xC3", 10'h386, 1'b0, 0, -1, 8'h00);
    check_idle("release idle");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
